// File: rtl/layer_sequencer.sv
// Runs the enabled pipeline stages one at a time through start/done handshakes.
// Each stage has a watchdog. The sequencer also measures the latency of every completed run.
module layer_sequencer #(
  parameter int NUM_STAGES     = 5,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int TMR_W          = 17,
  parameter int CYC_W          = 32,
  localparam int IDX_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_inference,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_enable,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [IDX_W-1:0]      cur_stage,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  error,
  output logic [IDX_W-1:0]      err_stage,
  output logic [CYC_W-1:0]      total_cycles
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINISH, ST_ERROR} state_t;

  state_t                  state_reg, state_next;
  logic [NUM_STAGES-1:0]   mask_reg, mask_next;
  logic [NUM_STAGES-1:0]   start_reg, start_next;
  logic [IDX_W-1:0]        cur_reg, cur_next;
  logic [IDX_W-1:0]        err_stage_reg, err_stage_next;
  logic [TMR_W-1:0]        timer_reg, timer_next;
  logic [CYC_W-1:0]        cyc_reg, cyc_next;
  logic [CYC_W-1:0]        total_reg, total_next;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;
  logic                    aborted_reg, aborted_next;
  logic                    error_reg, error_next;

  logic [NUM_STAGES-1:0]   above_mask;
  logic [IDX_W-1:0]        first_idx;
  logic [IDX_W-1:0]        next_idx;
  logic                    valid_done;
  logic                    timeout_hit;

  // Enabled stages strictly after the one being waited on
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_above
    assign above_mask[gi] = mask_reg[gi] && (IDX_W'(gi) > cur_reg);
  end

  always_comb begin
    first_idx = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (stage_enable[i]) first_idx = IDX_W'(i);
    end
  end

  always_comb begin
    next_idx = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (above_mask[i]) next_idx = IDX_W'(i);
    end
  end

  // A done that arrives together with the stage's own start pulse is stale.
  assign valid_done  = stage_done[cur_reg] && !(|start_reg);
  assign timeout_hit = (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      mask_reg      <= '0;
      start_reg     <= '0;
      cur_reg       <= '0;
      err_stage_reg <= '0;
      timer_reg     <= '0;
      cyc_reg       <= '0;
      total_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      aborted_reg   <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mask_reg      <= mask_next;
      start_reg     <= start_next;
      cur_reg       <= cur_next;
      err_stage_reg <= err_stage_next;
      timer_reg     <= timer_next;
      cyc_reg       <= cyc_next;
      total_reg     <= total_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      aborted_reg   <= aborted_next;
      error_reg     <= error_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mask_next      = mask_reg;
    start_next     = '0;
    cur_next       = cur_reg;
    err_stage_next = err_stage_reg;
    timer_next     = timer_reg;
    cyc_next       = cyc_reg;
    total_next     = total_reg;
    busy_next      = 1'b0;
    done_next      = 1'b0;
    aborted_next   = 1'b0;
    error_next     = error_reg;

    case (state_reg)
      ST_IDLE, ST_ERROR: begin
        if (start_inference) begin
          mask_next  = stage_enable;
          error_next = 1'b0;
          timer_next = '0;
          cyc_next   = '0;
          if (|stage_enable) begin
            cur_next              = first_idx;
            start_next[first_idx] = 1'b1;
            busy_next             = 1'b1;
            state_next            = ST_RUN;
          end else begin
            state_next = ST_FINISH;
          end
        end
      end

      ST_RUN: begin
        busy_next  = 1'b1;
        timer_next = timer_reg + 1'b1;
        cyc_next   = (&cyc_reg) ? cyc_reg : cyc_reg + 1'b1;
        if (abort) begin
          aborted_next = 1'b1;
          busy_next    = 1'b0;
          state_next   = ST_IDLE;
        end else if (valid_done) begin
          if (|above_mask) begin
            cur_next             = next_idx;
            start_next[next_idx] = 1'b1;
            timer_next           = '0;
          end else begin
            busy_next  = 1'b0;
            state_next = ST_FINISH;
          end
        end else if (timeout_hit) begin
          error_next     = 1'b1;
          err_stage_next = cur_reg;
          busy_next      = 1'b0;
          state_next     = ST_ERROR;
        end
      end

      ST_FINISH: begin
        total_next = cyc_reg;
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign stage_start  = start_reg;
  assign cur_stage    = cur_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign aborted      = aborted_reg;
  assign error        = error_reg;
  assign err_stage    = err_stage_reg;
  assign total_cycles = total_reg;

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Top-level inference controller that runs the CNN pipeline stages (conv, relu, maxpool, dense, argmax, ...) strictly in order.
- For each enabled stage it issues a one-cycle start pulse, then waits for that stage's done pulse before moving to the next stage.
- Adds a per-stage watchdog timeout, an abort path, and total-latency measurement.
- Sits above the layer modules and drives their start/done handshakes.

Parameters:
- NUM_STAGES, 5, number of sequenced stages; index 0 runs first.
- TIMEOUT_CYCLES, 65536, maximum cycles a stage may take, counted from its start pulse, before it is declared hung.
- TMR_W, 17, watchdog counter width; must satisfy 2^TMR_W > TIMEOUT_CYCLES.
- CYC_W, 32, total-cycle counter width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start_inference  input  1  request a run; accepted in IDLE or ERROR, ignored otherwise.
- abort  input  1  cancel the current run; effective only in RUN.
- stage_enable  input  NUM_STAGES  per-stage enable; sampled only on the accept cycle.
- stage_done  input  NUM_STAGES  one-cycle done pulses from the stages.
- stage_start  output  NUM_STAGES  one-hot, one-cycle start pulses to the stages.
- cur_stage  output  $clog2(NUM_STAGES) (min 1)  index of the stage being waited on.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a run completes.
- aborted  output  1  one-cycle pulse when a run is aborted.
- error  output  1  level; high while in ERROR.
- err_stage  output  $clog2(NUM_STAGES) (min 1)  stage that timed out; valid while error=1.
- total_cycles  output  CYC_W  latency of the last completed run.

Behaviour:
- Reset values:
  - state=IDLE.
  - stage_start=0, cur_stage=0, busy=0, done=0, aborted=0, error=0, err_stage=0, total_cycles=0.
  - Internal enable mask=0, timer=0, cycle counter=0.
- Reset mid-run: returns to IDLE immediately; no done or aborted pulse is issued.
- All outputs are registered.
- States: IDLE, RUN, FINISH, ERROR.
- IDLE/ERROR with start_inference=1 (accept cycle):
  - Latch stage_enable into the mask.
  - Clear error, timer and cycle counter.
  - If mask≠0: cur_stage ← lowest enabled index; stage_start ← onehot(that index); go to RUN. The stage sees its start pulse 1 cycle after accept.
  - If mask=0: go to FINISH directly; total_cycles becomes 0.
- RUN, every cycle:
  - stage_start defaults to 0.
  - timer increments; the cycle counter increments, saturating at all-ones.
  - busy=1.
- RUN, completion detect:
  - stage_done[cur_stage] counts only when stage_start is low in that cycle. A done coincident with the stage's own start pulse is treated as stale and ignored.
  - stage_done bits of any other stage are ignored.
- RUN, on valid done:
  - If a higher enabled stage exists: cur_stage ← next enabled index; stage_start ← its onehot in the next cycle; timer ← 0.
  - Otherwise: go to FINISH.
  - Disabled stages never receive a start pulse.
- RUN, timeout:
  - Fires when timer reaches TIMEOUT_CYCLES-1 without a valid done.
  - Go to ERROR; error ← 1; err_stage ← cur_stage; busy ← 0.
- RUN, abort=1:
  - Go to IDLE; aborted pulses for 1 cycle; busy ← 0.
  - Abort wins over a simultaneous done or timeout.
- FINISH (1 cycle):
  - total_cycles ← cycle counter, which covers the first RUN cycle through the final done cycle inclusive.
  - done pulses for 1 cycle; go to IDLE.
- ERROR:
  - Holds error=1 and err_stage until reset or an accepted start_inference.
  - A new start clears error in the accept cycle.
- start_inference in RUN or FINISH is ignored (not queued).
- abort outside RUN is ignored.

Test Plan:
- NUM_STAGES=5, all enabled, each stage model asserts done 10 cycles after seeing start -> start pulses appear on stages 0..4 in order, each exactly 1 cycle wide; done pulses once; total_cycles=55; busy low after done.
- stage_enable=5'b10100, 10-cycle stages -> start pulses only on stages 2 and 4; cur_stage goes 2→4; total_cycles=22.
- stage_enable=0 with start_inference -> done pulses 2 cycles after accept; no stage_start; total_cycles=0.
- TIMEOUT_CYCLES=100, stage 3 never responds -> error=1 and err_stage=3 after 100 cycles in stage 3; no done; a new start_inference clears error and reruns from stage 0.
- abort asserted while waiting on stage 1, in the same cycle stage_done[1] pulses -> aborted pulses; no stage_start[2]; no done; state returns to IDLE.
- Spurious stage_done[4] while waiting on stage 0, plus start_inference pulsed mid-run -> both ignored; sequence continues unchanged; reset asserted mid-run -> all outputs 0 on the next cycle.
